// File: rtl/toggle_gen_pkg.sv
// Purpose: shared types and default sizes for the toggle_gen stimulus generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package toggle_gen_pkg;

   localparam int CH_NUM_DEF = 4;
   localparam int CNT_W_DEF  = 16;
   localparam int NUM_W_DEF  = 16;

   // Per-channel FSM state, 2-bit encoded.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } state_t;

   // One channel's configuration at the default widths.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] half;
      logic [NUM_W_DEF-1:0] num;
      logic [CNT_W_DEF-1:0] tail;
      logic                 cont;
   } cfg_t;

endpackage

// File: rtl/toggle_gen_ch.sv
// Purpose: one square-wave channel (burst of N toggles + tail hold, or continuous).
// Latency: start seen in cycle c -> busy in c+1, toggle k visible in c+k*max(H,1).
// Backpressure: none; start while busy is dropped, stop aborts to idle next cycle.
// Ports: i_clk, i_rst (sync, active-high); i_half/i_num/i_tail/i_cont config,
//        latched on accepted start; i_start/i_stop requests;
//        o_out waveform, o_busy (RUN or TAIL), o_done (1-cycle burst completion).
module toggle_gen_ch
   import toggle_gen_pkg::*;
#(
   parameter int   CNT_W      = CNT_W_DEF,
   parameter int   NUM_W      = NUM_W_DEF,
   parameter logic INIT_LEVEL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [CNT_W-1:0] i_half,
   input  logic [NUM_W-1:0] i_num,
   input  logic [CNT_W-1:0] i_tail,
   input  logic             i_cont,
   input  logic             i_start,
   input  logic             i_stop,
   output logic             o_out,
   output logic             o_busy,
   output logic             o_done
);

   state_t           r_state;
   logic [CNT_W-1:0] r_half_m1;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] r_tail;
   logic [CNT_W-1:0] r_tail_cnt;
   logic [NUM_W-1:0] r_num;
   logic [NUM_W-1:0] r_tog;
   logic             r_cont;
   logic             r_out;
   logic             r_busy;
   logic             r_done;

   logic [CNT_W-1:0] w_half_m1;
   logic             w_wrap;
   logic [NUM_W-1:0] w_tog_nxt;

   // Store H_eff-1 so a programmed 0 behaves like 1.
   assign w_half_m1 = (i_half == '0) ? '0 : i_half - CNT_W'(1);
   assign w_wrap    = (r_phase == r_half_m1);
   assign w_tog_nxt = r_tog + NUM_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_half_m1  <= '0;
         r_phase    <= '0;
         r_tail     <= '0;
         r_tail_cnt <= '0;
         r_num      <= '0;
         r_tog      <= '0;
         r_cont     <= 1'b0;
         r_out      <= INIT_LEVEL;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  r_half_m1  <= w_half_m1;
                  r_num      <= i_num;
                  r_tail     <= i_tail;
                  r_cont     <= i_cont;
                  r_busy     <= 1'b1;
                  r_tail_cnt <= '0;
                  // The start cycle counts as phase 0, so with H_eff=1 the
                  // first toggle already lands at this edge.
                  if (!i_cont && i_num == '0) begin
                     // No toggles: the start cycle is tail cycle 0.
                     r_state    <= ST_TAIL;
                     r_out      <= INIT_LEVEL;
                     r_tog      <= '0;
                     r_phase    <= '0;
                     r_tail_cnt <= CNT_W'(1);
                  end else if (w_half_m1 == '0) begin
                     r_out   <= ~INIT_LEVEL;
                     r_tog   <= NUM_W'(1);
                     r_phase <= '0;
                     r_state <= (!i_cont && i_num == NUM_W'(1)) ? ST_TAIL : ST_RUN;
                  end else begin
                     r_out   <= INIT_LEVEL;
                     r_tog   <= '0;
                     r_phase <= CNT_W'(1);
                     r_state <= ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               if (i_stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_out   <= INIT_LEVEL;
               end else if (w_wrap) begin
                  r_phase <= '0;
                  r_out   <= ~r_out;
                  r_tog   <= w_tog_nxt;
                  // Continuous mode lets r_tog wrap freely.
                  if (!r_cont && w_tog_nxt == r_num) begin
                     r_state    <= ST_TAIL;
                     r_tail_cnt <= '0;
                  end
               end else begin
                  r_phase <= r_phase + CNT_W'(1);
               end
            end

            ST_TAIL: begin
               if (i_stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_out   <= INIT_LEVEL;
               end else if (r_tail_cnt >= r_tail) begin
                  // Final level is kept on o_out after completion.
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_tail_cnt <= r_tail_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_out  = r_out;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/toggle_gen.sv
// Purpose: CH_NUM independent square-wave stimulus channels on packed config buses.
// Latency: per channel, busy from c+1 after start in c; toggle k at c+k*max(H,1).
// Backpressure: none; start while busy ignored, stop aborts without done.
// Ports: i_clk, i_rst (sync, active-high); i_cfg_half/i_cfg_tail (CNT_W per channel),
//        i_cfg_num (NUM_W per channel), i_cfg_cont/i_start/i_stop (1 bit per channel);
//        o_out, o_busy, o_done (1 bit per channel). Channel i uses slice [i*W +: W].
module toggle_gen
   import toggle_gen_pkg::*;
#(
   parameter int   CH_NUM     = CH_NUM_DEF,
   parameter int   CNT_W      = CNT_W_DEF,
   parameter int   NUM_W      = NUM_W_DEF,
   parameter logic INIT_LEVEL = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [CH_NUM*CNT_W-1:0] i_cfg_half,
   input  logic [CH_NUM*NUM_W-1:0] i_cfg_num,
   input  logic [CH_NUM*CNT_W-1:0] i_cfg_tail,
   input  logic [CH_NUM-1:0]       i_cfg_cont,
   input  logic [CH_NUM-1:0]       i_start,
   input  logic [CH_NUM-1:0]       i_stop,
   output logic [CH_NUM-1:0]       o_out,
   output logic [CH_NUM-1:0]       o_busy,
   output logic [CH_NUM-1:0]       o_done
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      toggle_gen_ch #(
         .CNT_W      (CNT_W),
         .NUM_W      (NUM_W),
         .INIT_LEVEL (INIT_LEVEL)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_half  (i_cfg_half[i*CNT_W +: CNT_W]),
         .i_num   (i_cfg_num[i*NUM_W +: NUM_W]),
         .i_tail  (i_cfg_tail[i*CNT_W +: CNT_W]),
         .i_cont  (i_cfg_cont[i]),
         .i_start (i_start[i]),
         .i_stop  (i_stop[i]),
         .o_out   (o_out[i]),
         .o_busy  (o_busy[i]),
         .o_done  (o_done[i])
      );
   end

endmodule

// File: tb/tb_toggle_gen.sv
// Purpose: directed self-checking bench for toggle_gen (4 channels, 16-bit fields).
// Latency: outputs sampled 1ns after each rising edge = value of the new cycle.
// Backpressure: n/a.
module tb_toggle_gen;
   import toggle_gen_pkg::*;

   localparam int   CH = 4;
   localparam int   CW = 16;
   localparam int   NW = 16;
   localparam logic INIT = 1'b1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CH*CW-1:0]  cfg_half = '0;
   logic [CH*NW-1:0]  cfg_num  = '0;
   logic [CH*CW-1:0]  cfg_tail = '0;
   logic [CH-1:0]     cfg_cont = '0;
   logic [CH-1:0]     start    = '0;
   logic [CH-1:0]     stop     = '0;
   logic [CH-1:0]     out;
   logic [CH-1:0]     busy;
   logic [CH-1:0]     done;

   int n_total = 0;
   int n_pass  = 0;

   toggle_gen #(
      .CH_NUM     (CH),
      .CNT_W      (CW),
      .NUM_W      (NW),
      .INIT_LEVEL (INIT)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_cfg_half (cfg_half),
      .i_cfg_num  (cfg_num),
      .i_cfg_tail (cfg_tail),
      .i_cfg_cont (cfg_cont),
      .i_start    (start),
      .i_stop     (stop),
      .o_out      (out),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic set_cfg(input int ch, input cfg_t c);
      cfg_half[ch*CW +: CW] = c.half;
      cfg_num[ch*NW +: NW]  = c.num;
      cfg_tail[ch*CW +: CW] = c.tail;
      cfg_cont[ch]          = c.cont;
   endtask

   // Reference from the timing rules: toggle k at c+k*H_eff, done at
   // c+N*H_eff+T+1, busy strictly between c and done. Returns {out,busy,done}.
   function automatic logic [2:0] model(input cfg_t c, input int j);
      int   he, ntg, fin;
      logic o, b, d;
      he  = (c.half == 0) ? 1 : int'(c.half);
      ntg = j / he;
      if (c.cont) begin
         b = (j >= 1);
         d = 1'b0;
      end else begin
         if (ntg > int'(c.num)) ntg = int'(c.num);
         fin = int'(c.num) * he + int'(c.tail) + 1;
         b = (j >= 1) && (j < fin);
         d = (j == fin);
      end
      o = INIT ^ ntg[0];
      return {o, b, d};
   endfunction

   task automatic chk_ch(input string tst, input int ch, input cfg_t c, input int j);
      logic [2:0] m;
      m = model(c, j);
      chk($sformatf("%s_ch%0d_out_c+%0d", tst, ch, j),  {3'b0, out[ch]},  {3'b0, m[2]});
      chk($sformatf("%s_ch%0d_busy_c+%0d", tst, ch, j), {3'b0, busy[ch]}, {3'b0, m[1]});
      chk($sformatf("%s_ch%0d_done_c+%0d", tst, ch, j), {3'b0, done[ch]}, {3'b0, m[0]});
   endtask

   task automatic chk_reset_vals(input string tst);
      chk({tst, "_out"},  out,  4'b1111);
      chk({tst, "_busy"}, busy, 4'b0000);
      chk({tst, "_done"}, done, 4'b0000);
   endtask

   cfg_t c0, c1, c2, c3, c3b;
   cfg_t cc[CH];

   initial begin
      // Reset held 3 cycles, then released with no start.
      tick(3);
      chk_reset_vals("rst");
      rst = 1'b0;
      tick(5);
      chk_reset_vals("post_rst");

      // Ch0: H=10 N=100 T=100; cfg change mid-run must be ignored.
      c0 = '{half: 16'd10, num: 16'd100, tail: 16'd100, cont: 1'b0};
      set_cfg(0, c0);
      start[0] = 1'b1;
      tick(1);
      start[0] = 1'b0;
      cfg_half[0 +: CW] = 16'd3;
      for (int j = 1; j <= 1102; j++) begin
         chk_ch("burst", 0, c0, j);
         tick(1);
      end

      // Ch1: H=0 behaves as H=1, N=3 T=0 -> toggles c+1..c+3, done c+4, final 0.
      c1 = '{half: 16'd0, num: 16'd3, tail: 16'd0, cont: 1'b0};
      set_cfg(1, c1);
      start[1] = 1'b1;
      tick(1);
      start[1] = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         chk_ch("h0", 1, c1, j);
         tick(1);
      end
      chk("h0_final_out", {3'b0, out[1]}, 4'b0000);

      // Ch2: continuous H=4, stop raised in c+18.
      c2 = '{half: 16'd4, num: 16'd1, tail: 16'd7, cont: 1'b1};
      set_cfg(2, c2);
      start[2] = 1'b1;
      tick(1);
      start[2] = 1'b0;
      for (int j = 1; j <= 18; j++) begin
         chk_ch("cont", 2, c2, j);
         if (j == 18) stop[2] = 1'b1;
         tick(1);
      end
      stop[2] = 1'b0;
      chk("stop_out",  {3'b0, out[2]},  4'b0001);
      chk("stop_busy", {3'b0, busy[2]}, 4'b0000);
      chk("stop_done", {3'b0, done[2]}, 4'b0000);
      tick(2);
      chk("stop_idle_busy", {3'b0, busy[2]}, 4'b0000);
      // Start and stop together in IDLE: stop wins.
      start[2] = 1'b1;
      stop[2]  = 1'b1;
      tick(1);
      start[2] = 1'b0;
      stop[2]  = 1'b0;
      chk("startstop_busy", {3'b0, busy[2]}, 4'b0000);
      tick(3);
      chk("startstop_busy_later", {3'b0, busy[2]}, 4'b0000);
      chk("startstop_out", {3'b0, out[2]}, 4'b0001);

      // Ch3: N=0 T=5 -> done c+6; extra start while busy ignored;
      // a new start in the done cycle is accepted (N=0 T=2 -> done c'+3).
      c3  = '{half: 16'd2, num: 16'd0, tail: 16'd5, cont: 1'b0};
      c3b = '{half: 16'd2, num: 16'd0, tail: 16'd2, cont: 1'b0};
      set_cfg(3, c3);
      start[3] = 1'b1;
      tick(1);
      start[3] = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         chk_ch("n0", 3, c3, j);
         if (j == 2) start[3] = 1'b1;
         if (j == 3) start[3] = 1'b0;
         if (j == 6) begin
            set_cfg(3, c3b);
            start[3] = 1'b1;
         end
         tick(1);
      end
      start[3] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         chk_ch("restart", 3, c3b, j);
         tick(1);
      end

      // Concurrency: all channels started together, rst raised in c+8.
      cc[0] = '{half: 16'd3, num: 16'd5, tail: 16'd2, cont: 1'b0};
      cc[1] = '{half: 16'd1, num: 16'd4, tail: 16'd1, cont: 1'b0};
      cc[2] = '{half: 16'd2, num: 16'd0, tail: 16'd0, cont: 1'b1};
      cc[3] = '{half: 16'd5, num: 16'd2, tail: 16'd3, cont: 1'b0};
      for (int ch = 0; ch < CH; ch++) set_cfg(ch, cc[ch]);
      start = 4'b1111;
      tick(1);
      start = 4'b0000;
      for (int j = 1; j <= 8; j++) begin
         for (int ch = 0; ch < CH; ch++) chk_ch("conc", ch, cc[ch], j);
         if (j == 8) rst = 1'b1;
         tick(1);
      end
      chk_reset_vals("midrst");
      rst = 1'b0;
      for (int j = 0; j < 20; j++) begin
         chk_reset_vals($sformatf("after_rst_%0d", j));
         tick(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
